rtable_step_ctrl: RTL and testbench

- Initiator/reader side of the reward-table interface.
- Accepts an agent action for the current grid state and issues the packed {x,y,action} address to the reward table.
- Captures the reward one cycle after the read, computes the wall-clamped next state and goal/done, and returns a step result over a valid/ready handshake.
- Owns the agent position and the per-episode step count for the 8x8 gridworld.

---
 rtl/rtable_pkg.sv | 38 +++
 rtl/grid_next_state.sv | 38 +++
 rtl/rtable_step_ctrl.sv | 134 +++++++++++++
 tb/tb_rtable_step_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtable_pkg.sv
// Shared types and helpers for the gridworld reward-table step controller.
// Holds the action/FSM encodings, grid geometry, goal and start state, and
// the {x,y,action} reward-table address packer.
package rtable_pkg;

  localparam int X_BITS    = 3;
  localparam int Y_BITS    = 3;
  localparam int A_BITS    = 2;
  localparam int S_BITS    = X_BITS + Y_BITS;
  localparam int ADDR_BITS = S_BITS + A_BITS;

  typedef enum logic [A_BITS-1:0] {
    ACT_LEFT  = 2'b00,  // x-1
    ACT_UP    = 2'b01,  // y-1
    ACT_RIGHT = 2'b10,  // x+1
    ACT_DOWN  = 2'b11   // y+1
  } action_e;

  // The goal is the far corner of the grid; episodes restart at the origin.
  localparam logic [X_BITS-1:0] GOAL_X = '1;
  localparam logic [Y_BITS-1:0] GOAL_Y = '1;
  localparam logic [S_BITS-1:0] START  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fsm_e;

  function automatic logic [ADDR_BITS-1:0] pack_addr(
    input logic [S_BITS-1:0] state,
    input logic [A_BITS-1:0] action
  );
    return {state, action};
  endfunction

endpackage

// File: rtl/grid_next_state.sv
// Gridworld move: applies an action to {x,y}, clamping moves that would leave the grid.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: state_i {x,y}, action_i; next_state_o {x,y}, goal_o (next state is the goal).
module grid_next_state #(
  parameter int X_BITS = 3,
  parameter int Y_BITS = 3,
  parameter int A_BITS = 2
) (
  input  logic [X_BITS+Y_BITS-1:0] state_i,
  input  logic [A_BITS-1:0]        action_i,
  output logic [X_BITS+Y_BITS-1:0] next_state_o,
  output logic                     goal_o
);
  import rtable_pkg::*;

  logic [X_BITS-1:0] x, x_n;
  logic [Y_BITS-1:0] y, y_n;

  assign x = state_i[X_BITS+Y_BITS-1:Y_BITS];
  assign y = state_i[Y_BITS-1:0];

  // A move off the edge leaves the coordinate unchanged; nothing wraps.
  always_comb begin
    x_n = x;
    y_n = y;
    case (action_i)
      ACT_LEFT:  if (x != '0) x_n = x - X_BITS'(1);
      ACT_UP:    if (y != '0) y_n = y - Y_BITS'(1);
      ACT_RIGHT: if (x != '1) x_n = x + X_BITS'(1);
      ACT_DOWN:  if (y != '1) y_n = y + Y_BITS'(1);
      default:   ;
    endcase
  end

  assign next_state_o = {x_n, y_n};
  assign goal_o       = (x_n == X_BITS'(GOAL_X)) && (y_n == Y_BITS'(GOAL_Y));

endmodule

// File: rtl/rtable_step_ctrl.sv
// Reward-table initiator: takes an agent action, reads the reward table, returns a step result.
// Latency: 3 cycles accept-to-o_step_valid; at most one step per 4 cycles.
// Backpressure: o_act_ready low while a step is in flight; the result is held until i_step_ready.
// Ports: action in (i_act_valid/o_act_ready/i_action), table read (o_rt_addr/o_rt_read/i_rt_data),
//        step out (o_step_valid/i_step_ready/o_state/o_next_state/o_reward/o_done), o_episode_cnt.
// Build option: define RTABLE_STEP_CTRL_TIMEOUT_EN to also end an episode after MAX_STEPS steps.
module rtable_step_ctrl #(
  parameter int X_BITS     = 3,
  parameter int Y_BITS     = 3,
  parameter int A_BITS     = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STEPS  = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_act_valid,
  output logic                     o_act_ready,
  input  logic [A_BITS-1:0]        i_action,
  output logic [ADDR_WIDTH-1:0]    o_rt_addr,
  output logic                     o_rt_read,
  input  logic [DATA_WIDTH-1:0]    i_rt_data,
  output logic                     o_step_valid,
  input  logic                     i_step_ready,
  output logic [X_BITS+Y_BITS-1:0] o_state,
  output logic [X_BITS+Y_BITS-1:0] o_next_state,
  output logic [DATA_WIDTH-1:0]    o_reward,
  output logic                     o_done,
  output logic [15:0]              o_episode_cnt
);
  import rtable_pkg::*;

  localparam int ST_W  = X_BITS + Y_BITS;
  localparam int CNT_W = $clog2(MAX_STEPS) + 1;

  fsm_e                  fsm_q;
  logic                  act_rdy_q, rd_q, vld_q, done_q;
  logic [A_BITS-1:0]     act_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] reward_q;
  logic [ST_W-1:0]       state_q, nxt_q;
  logic [CNT_W-1:0]      step_cnt_q;
  logic [15:0]           ep_cnt_q;

  logic [ST_W-1:0]       nxt_state_d;
  logic                  goal_d, done_d;

  grid_next_state #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS),
    .A_BITS(A_BITS)
  ) u_grid (
    .state_i     (state_q),
    .action_i    (act_q),
    .next_state_o(nxt_state_d),
    .goal_o      (goal_d)
  );

  // step_cnt_q counts steps already taken this episode, so the current step
  // is the last one allowed when it reads MAX_STEPS-1.
`ifdef RTABLE_STEP_CTRL_TIMEOUT_EN
  assign done_d = goal_d | (step_cnt_q == CNT_W'(MAX_STEPS - 1));
`else
  assign done_d = goal_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q      <= IDLE;
      act_rdy_q  <= 1'b1;
      rd_q       <= 1'b0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      act_q      <= '0;
      addr_q     <= '0;
      reward_q   <= '0;
      state_q    <= START;
      nxt_q      <= '0;
      step_cnt_q <= '0;
      ep_cnt_q   <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (i_act_valid && act_rdy_q) begin
            act_q     <= i_action;
            addr_q    <= pack_addr(state_q, i_action);
            act_rdy_q <= 1'b0;
            rd_q      <= 1'b1;
            fsm_q     <= READ;
          end
        end
        READ: begin
          rd_q  <= 1'b0;
          fsm_q <= WAIT;
        end
        WAIT: begin
          // Table data is valid exactly this cycle (one after the read strobe).
          reward_q <= i_rt_data;
          nxt_q    <= nxt_state_d;
          done_q   <= done_d;
          vld_q    <= 1'b1;
          fsm_q    <= OUT;
        end
        OUT: begin
          if (i_step_ready) begin
            vld_q     <= 1'b0;
            act_rdy_q <= 1'b1;
            fsm_q     <= IDLE;
            if (done_q) begin
              state_q    <= START;
              step_cnt_q <= '0;
              if (ep_cnt_q != 16'hFFFF) ep_cnt_q <= ep_cnt_q + 16'd1;
            end else begin
              state_q <= nxt_q;
              if (step_cnt_q != '1) step_cnt_q <= step_cnt_q + CNT_W'(1);
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign o_act_ready   = act_rdy_q;
  assign o_rt_addr     = addr_q;
  assign o_rt_read     = rd_q;
  assign o_step_valid  = vld_q;
  assign o_state       = state_q;
  assign o_next_state  = nxt_q;
  assign o_reward      = reward_q;
  assign o_done        = done_q;
  assign o_episode_cnt = ep_cnt_q;

endmodule

// File: tb/tb_rtable_step_ctrl.sv
module tb_rtable_step_ctrl;

  localparam int MAX_STEPS = 16;
`ifdef RTABLE_STEP_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_act_valid;
  logic        o_act_ready;
  logic [1:0]  i_action;
  logic [7:0]  o_rt_addr;
  logic        o_rt_read;
  logic [31:0] i_rt_data;
  logic        o_step_valid;
  logic        i_step_ready;
  logic [5:0]  o_state;
  logic [5:0]  o_next_state;
  logic [31:0] o_reward;
  logic        o_done;
  logic [15:0] o_episode_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: agent position, steps this episode, completed episodes.
  int mx, my, steps, episodes;
  logic [31:0] rtab [256];

  rtable_step_ctrl #(
    .X_BITS(3), .Y_BITS(3), .A_BITS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_act_valid(i_act_valid), .o_act_ready(o_act_ready),
    .i_action(i_action), .o_rt_addr(o_rt_addr), .o_rt_read(o_rt_read), .i_rt_data(i_rt_data),
    .o_step_valid(o_step_valid), .i_step_ready(i_step_ready), .o_state(o_state),
    .o_next_state(o_next_state), .o_reward(o_reward), .o_done(o_done), .o_episode_cnt(o_episode_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reward table: data only meaningful the cycle after a read strobe, junk otherwise.
  always @(posedge i_clk) i_rt_data <= o_rt_read ? rtab[o_rt_addr] : $urandom;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic model_next(input logic [1:0] a, output logic [5:0] nxt, output logic done);
    int nx, ny;
    nx = mx; ny = my;
    case (a)
      2'd0: nx = mx - 1;
      2'd1: ny = my - 1;
      2'd2: nx = mx + 1;
      default: ny = my + 1;
    endcase
    if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin nx = mx; ny = my; end
    nxt  = {nx[2:0], ny[2:0]};
    done = (nx == 7 && ny == 7) || (TO_EN && steps == MAX_STEPS - 1);
  endtask

  task automatic model_commit(input logic [5:0] nxt, input logic done);
    if (done) begin
      mx = 0; my = 0; steps = 0;
      if (episodes < 65535) episodes++;
    end else begin
      mx = int'(nxt[5:3]); my = int'(nxt[2:0]); steps++;
    end
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_act_valid = 1'b0; i_step_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    mx = 0; my = 0; steps = 0; episodes = 0;
    @(negedge i_clk);
  endtask

  // One full step with checks at every phase; dly cycles of held-off ready in OUT,
  // and optionally a competing action offered while the controller is busy.
  task automatic do_step(input logic [1:0] a, input int dly, input bit hold_vld);
    logic [5:0] cur, nxt;
    logic done;
    logic [7:0] addr;
    logic [31:0] rw;
    int n;
    n = 0;
    while (o_act_ready !== 1'b1 && n < 20) begin @(negedge i_clk); n++; end
    checks++;
    if (o_act_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait o_act_ready=%b required 1", o_act_ready);
    end
    cur = {mx[2:0], my[2:0]};
    addr = {cur, a};
    rw = rtab[addr];
    model_next(a, nxt, done);
    i_act_valid = 1'b1; i_action = a;
    @(negedge i_clk);  // READ
    i_act_valid = hold_vld; i_action = 2'($urandom);
    checks++;
    if ({o_rt_read, o_act_ready, o_step_valid, o_rt_addr} !== {3'b100, addr}) begin
      errors++;
      $display("FAIL read_phase rd/rdy/vld/addr=%b%b%b/%h required 100/%h",
               o_rt_read, o_act_ready, o_step_valid, o_rt_addr, addr);
    end
    @(negedge i_clk);  // WAIT
    checks++;
    if ({o_rt_read, o_act_ready, o_step_valid} !== 3'b000) begin
      errors++;
      $display("FAIL wait_phase rd/rdy/vld=%b%b%b required 000", o_rt_read, o_act_ready, o_step_valid);
    end
    @(negedge i_clk);  // OUT
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) @(negedge i_clk);
      checks++;
      if ({o_step_valid, o_act_ready, o_rt_read, o_reward, o_next_state, o_done, o_state, o_rt_addr}
          !== {3'b100, rw, nxt, done, cur, addr}) begin
        errors++;
        $display("FAIL result_hold%0d vld=%b rdy=%b rw=%h nxt=%o done=%b st=%o addr=%h required vld=1 rdy=0 rw=%h nxt=%o done=%b st=%o addr=%h",
                 i, o_step_valid, o_act_ready, o_reward, o_next_state, o_done, o_state, o_rt_addr,
                 rw, nxt, done, cur, addr);
      end
    end
    i_step_ready = 1'b1; i_act_valid = 1'b0;
    @(negedge i_clk);
    i_step_ready = 1'b0;
    model_commit(nxt, done);
    checks++;
    if ({o_step_valid, o_act_ready, o_state, o_episode_cnt} !== {2'b01, mx[2:0], my[2:0], 16'(episodes)}) begin
      errors++;
      $display("FAIL after_handshake vld=%b rdy=%b st=%o ep=%0d required vld=0 rdy=1 st=%0d%0d ep=%0d",
               o_step_valid, o_act_ready, o_state, o_episode_cnt, mx, my, episodes);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_act_valid = 1'b0; i_action = 2'd0; i_step_ready = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_act_ready, o_rt_read, o_step_valid, o_rt_addr, o_reward, o_done, o_state, o_next_state, o_episode_cnt}
        !== {3'b100, 8'h00, 32'h0, 1'b0, 6'o00, 6'o00, 16'h0}) begin
      errors++; $display("FAIL reset_values rdy=%b rd=%b vld=%b addr=%h st=%o ep=%0d required 1 0 0 00 00 0",
                         o_act_ready, o_rt_read, o_step_valid, o_rt_addr, o_state, o_episode_cnt);
    end
    apply_reset();
    checks++;
    if ({o_act_ready, o_step_valid, o_state} !== {2'b10, 6'o00}) begin
      errors++; $display("FAIL reset_release rdy=%b vld=%b st=%o required 1 0 00", o_act_ready, o_step_valid, o_state);
    end
  endtask

  task automatic test_directed();
    rtab[8'h00] = 32'hFFFF_FF01;  // -255
    do_step(2'b00, 0, 1'b0);
    checks++;
    if ({o_reward, o_next_state, o_done} !== {32'hFFFF_FF01, 6'o00, 1'b0}) begin
      errors++; $display("FAIL corner_left rw=%h nxt=%o done=%b required ffffff01 00 0", o_reward, o_next_state, o_done);
    end
    repeat (3) do_step(2'b10, 0, 1'b0);
    repeat (4) do_step(2'b11, 0, 1'b0);
    rtab[8'b011_100_10] = 32'h0;
    do_step(2'b10, 1, 1'b0);
    checks++;
    if ({o_reward, o_next_state, o_state} !== {32'h0, 6'b100_100, 6'b100_100}) begin
      errors++; $display("FAIL move_right rw=%h nxt=%o st=%o required 0 44 44", o_reward, o_next_state, o_state);
    end
    repeat (3) do_step(2'b10, 0, 1'b0);
    repeat (2) do_step(2'b11, 0, 1'b0);
    do_step(2'b11, 0, 1'b0);
    checks++;
    if ({o_next_state, o_done, o_state, o_episode_cnt} !== {6'o77, 1'b1, 6'o00, 16'd1}) begin
      errors++; $display("FAIL goal nxt=%o done=%b st=%o ep=%0d required 77 1 00 1",
                         o_next_state, o_done, o_state, o_episode_cnt);
    end
  endtask

  task automatic test_hold();
    do_step(2'b11, 5, 1'b1);
    do_step(2'b10, 3, 1'b1);
  endtask

  // Action and result ports permanently open: one step every 4 cycles, none lost.
  task automatic test_back_to_back();
    logic [1:0] pend;
    logic [5:0] cur, nxt;
    logic done;
    int last, nsteps;
    last = -1; nsteps = 0; pend = 2'd0;
    i_step_ready = 1'b1; i_act_valid = 1'b0;
    for (int cyc = 0; cyc < 44; cyc++) begin
      @(negedge i_clk);
      if (o_step_valid === 1'b1) begin
        cur = {mx[2:0], my[2:0]};
        model_next(pend, nxt, done);
        checks++;
        if ({o_reward, o_next_state, o_done, o_state} !== {rtab[{cur, pend}], nxt, done, cur}) begin
          errors++; $display("FAIL b2b_result rw=%h nxt=%o done=%b st=%o required %h %o %b %o",
                             o_reward, o_next_state, o_done, o_state, rtab[{cur, pend}], nxt, done, cur);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin
            errors++; $display("FAIL b2b_spacing gap=%0d required 4", cyc - last);
          end
        end
        model_commit(nxt, done);
        last = cyc; nsteps++;
      end
      if (o_rt_read === 1'b1) begin
        checks++;
        if (o_rt_addr !== {mx[2:0], my[2:0], pend}) begin
          errors++; $display("FAIL b2b_addr addr=%h required %h", o_rt_addr, {mx[2:0], my[2:0], pend});
        end
      end
      if (o_act_ready === 1'b1) begin
        if (cyc < 36) begin
          i_act_valid = 1'b1;
          i_action = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'($urandom_range(2, 3));
          pend = i_action;
        end else i_act_valid = 1'b0;
      end
    end
    i_step_ready = 1'b0; i_act_valid = 1'b0;
    checks++;
    if (nsteps != 9) begin
      errors++; $display("FAIL b2b_count steps=%0d required 9", nsteps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 50; i++) begin
      do_step(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'($urandom_range(2, 3)),
              $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    do_step(2'b10, 0, 1'b0);
    do_step(2'b11, 0, 1'b0);
    i_act_valid = 1'b1; i_action = 2'b10;
    @(negedge i_clk);  // READ
    i_act_valid = 1'b0;
    @(negedge i_clk);  // WAIT
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_act_ready, o_rt_read, o_step_valid, o_rt_addr, o_reward, o_done, o_state, o_next_state, o_episode_cnt}
        !== {3'b100, 8'h00, 32'h0, 1'b0, 6'o00, 6'o00, 16'h0}) begin
      errors++; $display("FAIL mid_reset rdy=%b rd=%b vld=%b addr=%h rw=%h st=%o nxt=%o ep=%0d required reset values",
                         o_act_ready, o_rt_read, o_step_valid, o_rt_addr, o_reward, o_state, o_next_state, o_episode_cnt);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mx = 0; my = 0; steps = 0; episodes = 0;
    @(negedge i_clk);
    checks++;
    if ({o_step_valid, o_act_ready} !== 2'b01) begin
      errors++; $display("FAIL mid_reset_idle vld=%b rdy=%b required 0 1", o_step_valid, o_act_ready);
    end
    do_step(2'b11, 0, 1'b0);
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < MAX_STEPS; i++) do_step(2'b10, 0, 1'b0);
    checks++;
    if ({o_state, o_episode_cnt} !== (TO_EN ? {6'o00, 16'd1} : {6'o70, 16'd0})) begin
      errors++; $display("FAIL timeout st=%o ep=%0d required %s", o_state, o_episode_cnt,
                         TO_EN ? "00 1" : "70 0");
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_act_valid = 1'b0; i_action = 2'd0; i_step_ready = 1'b0;
    mx = 0; my = 0; steps = 0; episodes = 0;
    for (int i = 0; i < 256; i++) rtab[i] = $urandom;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
